// File: rtl/fadd_sched_pkg_81.sv
// Shared types and helpers for the float-adder scheduler: operand width,
// zero constant, ID width helper and the in-flight tag record.
package fadd_sched_pkg_81;

    localparam int FP_W     = 32;
    localparam int TAG_ID_W = 8;

    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fadd_sched_chk_81.sv
// Simulation checker: a retire must never hit a requester whose
// outstanding count is already zero.
module fadd_sched_chk_81 #(
    parameter int N = 4
) (
    input logic         i_clk,
    input logic         i_rst_n,
    input logic [N-1:0] i_underflow
);

    // Sample the underflow flags each cycle outside reset.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (i_underflow == '0);
        end
    end

endmodule

// File: rtl/rr_arbiter_81.sv
// Round-robin arbiter: the search starts at the pointer and wraps; the pointer
// moves one past the winner whenever the grant is accepted.
module rr_arbiter_81
    import fadd_sched_pkg_81::*;
#(
    parameter int N = 4,
    parameter int W = id_width(N)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_eligible,
    input  logic         i_accept,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_win_id
);

    logic [W-1:0] r_ptr;
    logic [N-1:0] w_grant;
    logic [W-1:0] w_win;
    logic [W-1:0] w_idx;
    logic         w_found;
    logic         w_hit;

    // First eligible requester at or after the pointer wins.
    always_comb begin
        w_grant = '0;
        w_win   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_idx          = W'((int'(r_ptr) + k) % N);
            w_hit          = ~w_found & i_eligible[w_idx];
            w_grant[w_idx] = w_grant[w_idx] | w_hit;
            w_win          = w_hit ? w_idx : w_win;
            w_found        = w_found | w_hit;
        end
    end

    // Pointer register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_accept) begin
            r_ptr <= W'((int'(w_win) + 1) % N);
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_grant  = w_grant;
    assign o_win_id = w_win;

endmodule

// File: rtl/fadd_sched_81.sv
// Shares one fixed-latency pipelined float adder between NUM_REQ requesters
// with round-robin issue, per-requester in-flight limits and tagged responses.
module fadd_sched_81
    import fadd_sched_pkg_81::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 3,
    parameter int MAX_OUT = 2
) (
    input  logic                          clk81,
    input  logic                          reset_81,
    input  logic [NUM_REQ-1:0]            req_valid_81,
    input  logic [32*NUM_REQ-1:0]         req_a_81,
    input  logic [32*NUM_REQ-1:0]         req_b_81,
    output logic [NUM_REQ-1:0]            req_ready_81,
    output logic [31:0]                   add_a81,
    output logic [31:0]                   add_b81,
    output logic                          add_reset_81,
    input  logic [31:0]                   add_result_81,
    output logic                          rsp_valid_81,
    output logic [id_width(NUM_REQ)-1:0]  rsp_id_81,
    output logic [31:0]                   rsp_result_81,
    output logic                          busy_81
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_retire;
    logic [NUM_REQ-1:0] w_underflow;
    logic [ID_W-1:0]    w_win;
    logic               w_xfer;
    logic [FP_W-1:0]    w_op_a;
    logic [FP_W-1:0]    w_op_b;
    logic               w_busy;

    logic [CNT_W-1:0]   r_out_cnt [NUM_REQ];
    tag_t               r_tag [ADD_LAT+1];
    logic [FP_W-1:0]    r_add_a;
    logic [FP_W-1:0]    r_add_b;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [FP_W-1:0]    r_rsp_result;

    // Eligibility is masked by reset so nothing is granted while held in reset.
    always_comb begin
        w_eligible  = '0;
        w_retire    = '0;
        w_underflow = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i]  = reset_81 & req_valid_81[i] & (r_out_cnt[i] < CNT_MAX);
            w_retire[i]    = r_rsp_valid & (r_rsp_id == ID_W'(i));
            w_underflow[i] = w_retire[i] & (r_out_cnt[i] == '0);
        end
    end

    rr_arbiter_81 #(
        .N (NUM_REQ)
    ) u_arb (
        .i_clk      (clk81),
        .i_rst_n    (reset_81),
        .i_eligible (w_eligible),
        .i_accept   (w_xfer),
        .o_grant    (w_grant),
        .o_win_id   (w_win)
    );

    assign w_xfer = |w_grant;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_op_a = FP_ZERO;
        w_op_b = FP_ZERO;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_op_a = w_op_a | (req_a_81[32*i +: 32] & {FP_W{w_grant[i]}});
            w_op_b = w_op_b | (req_b_81[32*i +: 32] & {FP_W{w_grant[i]}});
        end
    end

    // Issue registers and tag pipeline; tag stage ADD_LAT lines up with the adder output.
    always_ff @(posedge clk81 or negedge reset_81) begin
        if (!reset_81) begin
            r_add_a <= FP_ZERO;
            r_add_b <= FP_ZERO;
            for (int j = 0; j <= ADD_LAT; j++) begin
                r_tag[j] <= '0;
            end
        end else begin
            if (w_xfer) begin
                r_add_a  <= w_op_a;
                r_add_b  <= w_op_b;
                r_tag[0] <= {1'b1, TAG_ID_W'(w_win)};
            end else begin
                r_add_a  <= FP_ZERO;
                r_add_b  <= FP_ZERO;
                r_tag[0] <= '0;
            end
            for (int j = 1; j <= ADD_LAT; j++) begin
                r_tag[j] <= r_tag[j-1];
            end
        end
    end

    // Registered response taken from the last tag stage and the adder result.
    always_ff @(posedge clk81 or negedge reset_81) begin
        if (!reset_81) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= FP_ZERO;
        end else begin
            r_rsp_valid  <= r_tag[ADD_LAT].valid;
            r_rsp_id     <= ID_W'(r_tag[ADD_LAT].id);
            r_rsp_result <= r_tag[ADD_LAT].valid ? add_result_81 : FP_ZERO;
        end
    end

    // Outstanding counters: issue and retire on the same ID cancel out.
    always_ff @(posedge clk81 or negedge reset_81) begin
        if (!reset_81) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_out_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({w_grant[i], w_retire[i]})
                    2'b10:   r_out_cnt[i] <= (r_out_cnt[i] < CNT_MAX) ? r_out_cnt[i] + CNT_W'(1) : r_out_cnt[i];
                    2'b01:   r_out_cnt[i] <= (r_out_cnt[i] != '0) ? r_out_cnt[i] - CNT_W'(1) : r_out_cnt[i];
                    default: r_out_cnt[i] <= r_out_cnt[i];
                endcase
            end
        end
    end

    // An operation counts as in flight until its response cycle ends.
    always_comb begin
        w_busy = r_rsp_valid;
        for (int j = 0; j <= ADD_LAT; j++) begin
            w_busy = w_busy | r_tag[j].valid;
        end
    end

    fadd_sched_chk_81 #(
        .N (NUM_REQ)
    ) u_chk (
        .i_clk       (clk81),
        .i_rst_n     (reset_81),
        .i_underflow (w_underflow)
    );

    assign req_ready_81  = w_grant;
    assign add_a81       = r_add_a;
    assign add_b81       = r_add_b;
    assign add_reset_81  = ~reset_81;
    assign rsp_valid_81  = r_rsp_valid;
    assign rsp_id_81     = r_rsp_id;
    assign rsp_result_81 = r_rsp_result;
    assign busy_81       = w_busy;

endmodule

// File: doc/fadd_sched_81.md
Name: fadd_sched_81

Overview:
Shares one pipelined single-precision adder (float_add_81, fixed latency, no stall) between NUM_REQ requesters. Runs round-robin arbitration with a per-requester outstanding-operation limit, and issues at most one operand pair per cycle. Tags each issued operation and routes the adder result back with the requester ID. Sits between client blocks and the float_add_81 instance.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
ADD_LAT, 3, adder latency in cycles from operands valid at its inputs to result valid at its output (>=1)
MAX_OUT, 2, maximum in-flight operations per requester (>=1)

Ports:
clk81  in  1  clock, rising edge
reset_81  in  1  asynchronous, active-low reset
req_valid_81  in  NUM_REQ  per-requester operation valid
req_a_81  in  32*NUM_REQ  operand A, requester i in bits [32i+31:32i]
req_b_81  in  32*NUM_REQ  operand B, same packing
req_ready_81  out  NUM_REQ  one-hot grant; transfer when valid&ready
add_a81  out  32  operand A to adder
add_b81  out  32  operand B to adder
add_reset_81  out  1  active-high reset to adder, equal to ~reset_81
add_result_81  in  32  adder result
rsp_valid_81  out  1  response valid, single-cycle pulse per op
rsp_id_81  out  max(1,clog2(NUM_REQ))  requester ID of response
rsp_result_81  out  32  sum; 0 when rsp_valid_81=0
busy_81  out  1  any operation in flight

Behaviour:
- Reset (reset_81=0, async): rr_ptr=0; all outstanding counters 0; issue/tag pipeline valid bits cleared; add_a81=add_b81=0; rsp_valid_81=0, rsp_id_81=0, rsp_result_81=0; busy_81=0; req_ready_81=0. Any in-flight operation is dropped and never responds. The adder is reset through add_reset_81.
- Eligibility: requester i is eligible when req_valid_81[i]=1 and out_cnt[i]<MAX_OUT.
- Arbitration (combinational): search starts at rr_ptr and wraps modulo NUM_REQ. The first eligible requester wins, and only its req_ready_81 bit is high. No eligible requester gives req_ready_81=0.
- rr_ptr update: on a transfer, rr_ptr <= (winner+1) mod NUM_REQ. Otherwise unchanged.
- Issue stage (registered): at a transfer edge, add_a81/add_b81 <= the winner's operands, and tag stage 0 <= {1, winner ID}. With no transfer, add_a81/add_b81 <= 0 and tag stage 0 valid <= 0.
- Tag pipeline: ADD_LAT further stages, shifted every cycle with no stall. rsp_valid_81/rsp_id_81 are taken from the last stage. rsp_result_81 = add_result_81 gated by rsp_valid_81.
- Latency: handshake sampled at edge k gives rsp_valid_81 high in the cycle after edge k+ADD_LAT+1. Sustained throughput is 1 op/cycle. Responses come back in issue order.
- Outstanding counters: +1 on issue for the winner, -1 when a response retires for rsp_id_81. Same-cycle issue and retire on the same ID leaves the counter unchanged. A counter never exceeds MAX_OUT and never underflows; an underflow is an assertion failure in simulation.
- busy_81 = OR of all issue/tag valid bits.
- No response backpressure: clients must accept rsp_valid_81 in the cycle it is asserted.
- A requester may drop req_valid_81 without a transfer. Operands are sampled only on the transfer edge.
- NUM_REQ=1: the arbiter degenerates to eligibility only, and rsp_id_81 is always 0.

Decomposition:
- Package fadd_sched_pkg_81 holds:
  - FP_W=32
  - FP_ZERO constant
  - id_width(n) function, returning max(1,clog2(n))
  - tag struct {valid, id}
- Sub-module rr_arbiter_81 (parameter N) holds the rr_ptr register.
  - Inputs: eligible vector, accept.
  - Outputs: one-hot grant, binary winner ID.
- Counters, tag pipeline and operand registers stay in fadd_sched_81.

Test Plan:
1. Reset asserted with req_valid_81=4'b1111 -> req_ready_81=0, rsp_valid_81=0, add_a81=add_b81=0, busy_81=0. Release -> next cycle grants requester 0.
2. Requester 0 only: a=0x42C40000 (98), b=0x43290000 (169) -> single rsp_valid_81 pulse ADD_LAT+1 cycles after the handshake, rsp_id_81=0, rsp_result_81=0x43858000 (267).
3. All four requesters valid continuously with distinct pairs -> grant order 0,1,2,3,0,... one per cycle; back-to-back responses in the same ID order. Requester 1: 99+(-89) -> 0x41200000. Requester 2: -45+79 -> 0x42080000. Requester 3: 0+0 -> 0x00000000.
4. MAX_OUT=2, only requester 1 valid, ADD_LAT=3 -> ready high for 2 cycles, then low until the first response retires. Ready reasserts in the cycle after that retire edge and never exceeds 2 in flight.
5. Issue and retire for the same ID in the same cycle -> out_cnt unchanged; a further issue is allowed iff the count is below MAX_OUT.
6. Reset pulsed low with 3 ops in flight -> busy_81=0 immediately; no rsp_valid_81 afterwards; first post-reset grant goes to requester 0 and its response is correct.
